// File: rtl/mmap_decoder.sv
// Memory-map decoder and response tracker: routes one outstanding core request to the
// first matching base/top region, returns its response, and reports unmapped or timed-out accesses.
module mmap_decoder #(
  parameter int unsigned                NUM_REGIONS = 4,
  parameter logic [NUM_REGIONS*32-1:0] REGION_BASE = {32'h0C000000, 32'h02000000, 32'h00100000, 32'h00000000},
  parameter logic [NUM_REGIONS*32-1:0] REGION_TOP  = {32'h10000000, 32'h0200C000, 32'h00100004, 32'h00010000},
  parameter int unsigned                TIMEOUT     = 1024,
  parameter int unsigned                ERR_WIDTH   = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      m_valid,
  input  logic                      m_instr,
  input  logic [31:0]               m_addr,
  input  logic [31:0]               m_wdata,
  input  logic [3:0]                m_wstrb,
  output logic [31:0]               m_rdata,
  output logic                      m_ready,
  output logic                      m_error,
  output logic [NUM_REGIONS-1:0]    s_valid,
  output logic                      s_instr,
  output logic [31:0]               s_addr,
  output logic [31:0]               s_wdata,
  output logic [3:0]                s_wstrb,
  input  logic [NUM_REGIONS*32-1:0] s_rdata,
  input  logic [NUM_REGIONS-1:0]    s_ready,
  output logic [ERR_WIDTH-1:0]      err_count
);

  localparam int unsigned SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_e;

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   m_ready_q, m_ready_d;
  logic                   m_error_q, m_error_d;
  logic [31:0]            m_rdata_q, m_rdata_d;
  logic [NUM_REGIONS-1:0] s_valid_q, s_valid_d;
  logic                   s_instr_q, s_instr_d;
  logic [31:0]            s_addr_q, s_addr_d;
  logic [31:0]            s_wdata_q, s_wdata_d;
  logic [3:0]             s_wstrb_q, s_wstrb_d;
  logic [ERR_WIDTH-1:0]   err_q, err_d;

  logic                   hit;
  logic [SEL_W-1:0]       hit_idx;
  logic                   tgt_ready;
  logic [31:0]            tgt_rdata;
  logic                   timeout_hit;
  logic                   err_rsp;

  // Scanning from the top index down lets the lowest matching region overwrite the others.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (m_addr >= REGION_BASE[32*i +: 32] && m_addr < REGION_TOP[32*i +: 32]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    tgt_ready = 1'b0;
    tgt_rdata = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (sel_q == SEL_W'(i)) begin
        tgt_ready = s_ready[i];
        tgt_rdata = s_rdata[32*i +: 32];
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    m_ready_d = 1'b0;
    m_error_d = 1'b0;
    m_rdata_d = m_rdata_q;
    s_valid_d = '0;
    s_instr_d = s_instr_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wstrb_d = s_wstrb_q;
    err_d     = err_q;
    err_rsp   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A request arriving in the response cycle itself is dropped.
        if (m_valid && !m_ready_q) begin
          s_instr_d = m_instr;
          s_addr_d  = m_addr;
          s_wdata_d = m_wdata;
          s_wstrb_d = m_wstrb;
          if (hit) begin
            sel_d     = hit_idx;
            s_valid_d = NUM_REGIONS'(1) << hit_idx;
            cnt_d     = '0;
            state_d   = BUSY;
          end else begin
            err_rsp = 1'b1;
            state_d = ERR;
          end
        end
      end
      BUSY: begin
        if (tgt_ready) begin
          m_ready_d = 1'b1;
          m_rdata_d = tgt_rdata;
          state_d   = IDLE;
        end else if (timeout_hit) begin
          err_rsp = 1'b1;
          state_d = ERR;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (err_rsp) begin
      m_ready_d = 1'b1;
      m_error_d = 1'b1;
      m_rdata_d = '0;
      if (err_q != '1) err_d = err_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      m_ready_q <= 1'b0;
      m_error_q <= 1'b0;
      m_rdata_q <= '0;
      s_valid_q <= '0;
      s_instr_q <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_wstrb_q <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      m_ready_q <= m_ready_d;
      m_error_q <= m_error_d;
      m_rdata_q <= m_rdata_d;
      s_valid_q <= s_valid_d;
      s_instr_q <= s_instr_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wstrb_q <= s_wstrb_d;
      err_q     <= err_d;
    end
  end

  assign m_ready   = m_ready_q;
  assign m_error   = m_error_q;
  assign m_rdata   = m_rdata_q;
  assign s_valid   = s_valid_q;
  assign s_instr   = s_instr_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign s_wstrb   = s_wstrb_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_mmap_decoder.sv
// Directed bench for mmap_decoder: region 1 is widened down to 0x8000 so it overlaps region 0,
// with an 8-cycle timeout and a 2-bit error counter.
module tb_mmap_decoder;

  logic         clock;
  logic         reset;
  logic         m_valid;
  logic         m_instr;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [3:0]   m_wstrb;
  logic [31:0]  m_rdata;
  logic         m_ready;
  logic         m_error;
  logic [3:0]   s_valid;
  logic         s_instr;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic [127:0] s_rdata;
  logic [3:0]   s_ready;
  logic [1:0]   err_count;

  int total = 0;
  int bad   = 0;

  mmap_decoder #(
    .NUM_REGIONS (4),
    .REGION_BASE ({32'h0C000000, 32'h02000000, 32'h00008000, 32'h00000000}),
    .REGION_TOP  ({32'h10000000, 32'h0200C000, 32'h00100004, 32'h00010000}),
    .TIMEOUT     (8),
    .ERR_WIDTH   (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .m_valid   (m_valid),
    .m_instr   (m_instr),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready),
    .m_error   (m_error),
    .s_valid   (s_valid),
    .s_instr   (s_instr),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_rdata   (s_rdata),
    .s_ready   (s_ready),
    .err_count (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives a one-cycle request; returns one step after the accepting edge (cycle T+1).
  task automatic req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, input logic ins);
    m_addr  = a;
    m_wdata = wd;
    m_wstrb = ws;
    m_instr = ins;
    m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] miss_addr [5];
    logic [1:0]  sat_exp   [5];
    miss_addr = '{32'h00100004, 32'h0200C000, 32'hFFFFFFFF, 32'h01000000, 32'h0BFFFFFF};
    sat_exp   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    reset = 1'b0; m_valid = 1'b0; m_instr = 1'b0; m_addr = '0;
    m_wdata = '0; m_wstrb = '0; s_rdata = '0; s_ready = '0;
    tick(); tick();
    check("rst_m_ready", m_ready, 0);
    check("rst_s_valid", s_valid, 0);
    check("rst_err", err_count, 0);
    check("rst_s_addr", s_addr, 0);
    reset = 1'b1;
    tick();

    // Read hit, region 0, instruction fetch; target answers at T+3.
    req(32'h00000010, 32'h0, 4'h0, 1'b1);
    check("rd_s_valid", s_valid, 4'b0001);
    check("rd_s_addr", s_addr, 32'h10);
    check("rd_s_instr", s_instr, 1);
    check("rd_no_ready_t1", m_ready, 0);
    tick();
    check("rd_s_valid_pulse", s_valid, 0);
    tick();
    s_ready = 4'b0001; s_rdata[31:0] = 32'hDEADBEEF;
    tick();
    s_ready = 4'b0000;
    check("rd_m_ready", m_ready, 1);
    check("rd_m_error", m_error, 0);
    check("rd_m_rdata", m_rdata, 32'hDEADBEEF);
    tick();
    check("rd_ready_pulse", m_ready, 0);

    // Write to UART with s_ready coincident with s_valid.
    req(32'h00100000, 32'h41, 4'b0001, 1'b0);
    check("wr_s_valid", s_valid, 4'b0010);
    check("wr_s_wstrb", s_wstrb, 4'b0001);
    check("wr_s_wdata", s_wdata, 32'h41);
    check("wr_s_instr", s_instr, 0);
    s_ready = 4'b0010; s_rdata[63:32] = 32'h0000_0055;
    tick();
    s_ready = 4'b0000;
    check("wr_m_ready", m_ready, 1);
    check("wr_m_error", m_error, 0);
    check("wr_m_rdata", m_rdata, 32'h55);
    // A request during the response cycle is dropped.
    req(32'h00000010, 32'h0, 4'h0, 1'b0);
    check("wr_rsp_cycle_drop", s_valid, 0);
    check("wr_rsp_cycle_noready", m_ready, 0);

    // Unmapped: exclusive top of region 1.
    req(32'h00100004, 32'h0, 4'h0, 1'b0);
    check("miss_s_valid", s_valid, 0);
    check("miss_m_ready", m_ready, 1);
    check("miss_m_error", m_error, 1);
    check("miss_m_rdata", m_rdata, 0);
    check("miss_err_count", err_count, 1);
    req(32'h00000010, 32'h0, 4'h0, 1'b0);
    check("miss_rsp_cycle_drop", s_valid, 0);
    check("miss_ready_pulse", m_ready, 0);

    // Timeout on region 3: no response in T+1..T+8, error at T+9.
    req(32'h0C000000, 32'h0, 4'h0, 1'b0);
    check("to_s_valid", s_valid, 4'b1000);
    repeat (7) tick();
    check("to_none_t8", m_ready, 0);
    tick();
    check("to_m_ready", m_ready, 1);
    check("to_m_error", m_error, 1);
    check("to_m_rdata", m_rdata, 0);
    check("to_err_count", err_count, 2);
    s_ready = 4'b1000; s_rdata[127:96] = 32'hCAFEF00D;
    tick();
    s_ready = 4'b0000;
    check("to_late_ignored", m_ready, 0);
    tick();
    check("to_late_ignored2", m_ready, 0);

    // Next request after timeout; region 2 base is inclusive.
    req(32'h02000000, 32'h0, 4'h0, 1'b0);
    check("after_to_s_valid", s_valid, 4'b0100);
    s_ready = 4'b0100; s_rdata[95:64] = 32'h0BADF00D;
    tick();
    s_ready = 4'b0000;
    check("after_to_m_ready", m_ready, 1);
    check("after_to_m_rdata", m_rdata, 32'h0BADF00D);
    tick();

    // Response at exactly T+TIMEOUT completes normally.
    req(32'h0200BFFC, 32'h0, 4'h0, 1'b0);
    check("edge_s_valid", s_valid, 4'b0100);
    repeat (6) tick();
    check("edge_none_t7", m_ready, 0);
    tick();
    s_ready = 4'b0100; s_rdata[95:64] = 32'h12345678;
    tick();
    s_ready = 4'b0000;
    check("edge_m_ready", m_ready, 1);
    check("edge_m_error", m_error, 0);
    check("edge_m_rdata", m_rdata, 32'h12345678);
    check("edge_err_count", err_count, 2);
    tick();

    // Overlap of regions 0 and 1 picks region 0; s_ready on region 1 is ignored.
    req(32'h00008000, 32'h0, 4'h0, 1'b0);
    check("ovl_s_valid", s_valid, 4'b0001);
    s_ready = 4'b0010; s_rdata[31:0] = 32'hA5A5A5A5;
    tick();
    check("ovl_wrong_ready", m_ready, 0);
    s_ready = 4'b0001;
    tick();
    s_ready = 4'b0000;
    check("ovl_m_ready", m_ready, 1);
    check("ovl_m_rdata", m_rdata, 32'hA5A5A5A5);
    tick();

    // Reset while BUSY abandons the transaction.
    req(32'h00000020, 32'h77, 4'hF, 1'b1);
    check("rb_s_valid", s_valid, 4'b0001);
    tick();
    reset = 1'b0;
    #2;
    check("rb_m_ready", m_ready, 0);
    check("rb_s_valid0", s_valid, 0);
    check("rb_s_addr", s_addr, 0);
    check("rb_s_wdata", s_wdata, 0);
    check("rb_s_wstrb", s_wstrb, 0);
    check("rb_s_instr", s_instr, 0);
    check("rb_m_rdata", m_rdata, 0);
    check("rb_err", err_count, 0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    s_ready = 4'b0001; s_rdata[31:0] = 32'h11112222;
    tick();
    s_ready = 4'b0000;
    check("rb_post_ready_ignored", m_ready, 0);
    tick();
    check("rb_post_ready_ignored2", m_ready, 0);
    req(32'h00000030, 32'h0, 4'h0, 1'b0);
    check("rb_new_s_valid", s_valid, 4'b0001);
    check("rb_new_s_addr", s_addr, 32'h30);
    s_ready = 4'b0001; s_rdata[31:0] = 32'h33334444;
    tick();
    s_ready = 4'b0000;
    check("rb_new_m_ready", m_ready, 1);
    check("rb_new_m_rdata", m_rdata, 32'h33334444);
    tick();

    // Five misses saturate a 2-bit counter at 3.
    for (int i = 0; i < 5; i++) begin
      req(miss_addr[i], 32'h0, 4'h0, 1'b0);
      check($sformatf("sat_err_%0d", i), m_error, 1);
      check($sformatf("sat_cnt_%0d", i), err_count, sat_exp[i]);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmap_decoder.md
# mmap_decoder

Parametrised memory-map decoder and response tracker between the core memory port and N peripheral targets (BRAM, UART, CLINT, PLIC, …). It replaces the fixed per-peripheral address compares with a table of NUM_REGIONS base/top pairs. It adds three behaviours the fixed map lacks:
- error responses for unmapped addresses;
- a per-transaction response timeout;
- a saturating error counter.

## Interface
Parameters:
- NUM_REGIONS, 4, number of target regions (1..16).
- REGION_BASE, {32'h0C000000, 32'h2000000, 32'h100000, 32'h0}, packed NUM_REGIONS×32; region i at bits [32i+31:32i], inclusive base.
- REGION_TOP, {32'h10000000, 32'h200C000, 32'h100004, 32'h10000}, packed NUM_REGIONS×32; exclusive top.
- TIMEOUT, 1024, response timeout in cycles; 0 disables the timeout.
- ERR_WIDTH, 8, width of the error counter.

Ports:
- reset  in  1  asynchronous, active-low reset
- clock  in  1  clock
- m_valid  in  1  request pulse from master
- m_instr  in  1  instruction-fetch flag (forwarded)
- m_addr  in  32  request address
- m_wdata  in  32  write data
- m_wstrb  in  4  byte strobes; 0 = read
- m_rdata  out  32  response data
- m_ready  out  1  response pulse
- m_error  out  1  error qualifier, valid with m_ready
- s_valid  out  NUM_REGIONS  one-hot request pulse to targets
- s_instr  out  1  registered m_instr
- s_addr  out  32  registered address, absolute (not rebased)
- s_wdata  out  32  registered write data
- s_wstrb  out  4  registered strobes
- s_rdata  in  NUM_REGIONS×32  target read data
- s_ready  in  NUM_REGIONS  target response pulses
- err_count  out  ERR_WIDTH  saturating count of error responses

## Operation
- States: IDLE, BUSY, ERR.
- **IDLE, m_valid=1:**
  - Register instr, addr, wdata and wstrb.
  - Region i hits when REGION_BASE[i] ≤ m_addr < REGION_TOP[i], using unsigned 32-bit compares.
  - If several regions hit, the lowest index wins.
  - Hit: latch sel=i, pulse s_valid[i] for exactly one cycle, clear the timeout counter, go to BUSY.
  - Miss: no s_valid pulse, go to ERR.
- **ERR:**
  - Drive m_ready=1, m_error=1, m_rdata=0 for one cycle.
  - Increment err_count.
  - Go to IDLE.
- **BUSY:**
  - Only s_ready[sel] is observed; s_ready on any other index is ignored.
  - On s_ready[sel]=1: next cycle drive m_ready=1, m_error=0, m_rdata=registered s_rdata[sel], then go to IDLE.
  - Otherwise the counter increments.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT with no s_ready[sel], respond exactly as in ERR (err_count included) and go to IDLE.
  - A late s_ready from the abandoned target is ignored.
- m_valid outside IDLE is ignored; the master issues at most one outstanding request.
- A response cycle returns to IDLE. An m_valid in that same cycle is ignored, so the earliest accepted next request is the cycle after m_ready.
- err_count saturates at 2^ERR_WIDTH−1 and does not wrap.
- Reset values: state=IDLE, m_ready=0, m_error=0, m_rdata=0, s_valid=0, s_instr=0, s_addr=0, s_wdata=0, s_wstrb=0, err_count=0, counter=0.
- Reset mid-transaction abandons it: no m_ready is produced, and any post-reset s_ready is ignored.

## Timing
- m_valid at cycle T:
  - Hit: s_valid[sel] and s_* outputs at T+1.
  - Miss: m_ready/m_error at T+1.
- s_ready[sel] at cycle R, where R ≥ T+1 (an s_ready coincident with s_valid is accepted): m_ready at R+1. Minimum round trip is 2 cycles.
- Timeout: if no s_ready[sel] arrives in cycles T+1 … T+TIMEOUT, m_ready with m_error=1 is driven at T+TIMEOUT+1. An s_ready at exactly T+TIMEOUT completes normally.
- m_ready, m_error and s_valid are single-cycle pulses.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Read hit, region 0:** m_valid, addr 0x10, s_ready[0] at T+3 with rdata 0xDEADBEEF → s_valid=4'b0001 at T+1; m_ready=1, m_error=0, m_rdata=0xDEADBEEF at T+4.
- **Write to UART:** addr 0x100000, wstrb 4'b0001, wdata 0x41 → s_valid[1] at T+1 with s_wstrb=1 and s_wdata=0x41; s_ready[1] at T+1 gives m_ready at T+2.
- **Unmapped address:** addr 0x100004 (exclusive top) → no s_valid; m_ready=1, m_error=1, m_rdata=0 at T+1; err_count=1.
- **Timeout:** TIMEOUT=8, target never responds → m_error pulse at T+9. A later s_ready[sel] has no effect. The next request is serviced normally.
- **Boundaries and overlap:** overlapping regions 0 and 1 select index 0. s_ready at exactly T+TIMEOUT gives a normal response. err_count with ERR_WIDTH=2 saturates at 3 after 5 misses.
- **Reset mid-BUSY:** reset asserted, then s_ready pulsed → outputs at reset values and no m_ready. The post-reset request completes normally.
